// File: rtl/led_scanner.sv
// Scanning LED bar: a fractional position sweeps across CHANNELS outputs and
// crossfades neighbouring channels through per-channel PWM.
module led_scanner #(
  parameter int CHANNELS  = 8,
  parameter int PWM_BITS  = 10,
  parameter int FRAC_BITS = 21
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          mode,
  input  logic [7:0]          step,
  input  logic [7:0]          scale,
  output logic [CHANNELS-1:0] led,
  output logic                end_pulse
);

  localparam int IDX_W = $clog2(CHANNELS);
  localparam int PW    = IDX_W + FRAC_BITS;
  // Wide enough that neither PMAX+step nor the comparisons can overflow, even
  // when the position is narrower than the 8-bit step.
  localparam int AW    = (PW + 1 > 9) ? PW + 1 : 9;

  localparam logic [AW-1:0]       PMAX = (AW'(CHANNELS) << FRAC_BITS) - AW'(1);
  localparam logic [PWM_BITS-1:0] BMAX = '1;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_WRAP   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  mode_e mode_s;
  assign mode_s = mode_e'(mode);

  logic [PW-1:0]       p_q, p_d;
  logic                dir_q, dir_d;
  logic                end_pulse_q, end_pulse_d;
  logic [PWM_BITS-1:0] pwm_ctr_q;
  logic [CHANNELS-1:0] led_q, led_d;

  logic [AW-1:0] p_ext, step_ext, sum, diff;
  assign p_ext    = AW'(p_q);
  assign step_ext = AW'(step);
  assign sum      = p_ext + step_ext;
  assign diff     = p_ext - step_ext;

  always_comb begin
    p_d         = p_q;
    dir_d       = dir_q;
    end_pulse_d = 1'b0;
    if (step != 8'd0) begin
      case (mode_s)
        MODE_BOUNCE: begin
          if (!dir_q) begin
            if (sum > PMAX) begin
              p_d         = PW'(PMAX);
              dir_d       = 1'b1;
              end_pulse_d = 1'b1;
            end else begin
              p_d = PW'(sum);
            end
          end else begin
            if (p_ext < step_ext) begin
              p_d         = '0;
              dir_d       = 1'b0;
              end_pulse_d = 1'b1;
            end else begin
              p_d = PW'(diff);
            end
          end
        end
        MODE_WRAP: begin
          if (sum > PMAX) begin
            // Modulo rather than a single subtract: step may exceed the range.
            p_d         = PW'(sum % (PMAX + AW'(1)));
            end_pulse_d = 1'b1;
          end else begin
            p_d = PW'(sum);
          end
        end
        default: ;
      endcase
    end
  end

  logic [IDX_W-1:0]    idx;
  logic [PWM_BITS-1:0] frac_hi;
  logic                wrap_nb;
  assign idx     = p_q[PW-1 -: IDX_W];
  assign frac_hi = p_q[FRAC_BITS-1 -: PWM_BITS];
  assign wrap_nb = (mode_s == MODE_WRAP);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      localparam int PREV = (gi == 0) ? CHANNELS - 1 : gi - 1;
      localparam int NEXT = (gi == CHANNELS - 1) ? 0 : gi + 1;

      logic [PWM_BITS-1:0]   raw;
      logic [PWM_BITS+7:0]   prod;
      logic [PWM_BITS-1:0]   duty;

      // Edge channels only see the far neighbour when the sweep wraps.
      always_comb begin
        raw = '0;
        if (idx == IDX_W'(gi))
          raw = BMAX;
        else if (idx == IDX_W'(PREV) && (gi != 0 || wrap_nb))
          raw = frac_hi;
        else if (idx == IDX_W'(NEXT) && (gi != CHANNELS - 1 || wrap_nb))
          raw = BMAX - frac_hi;
      end

      assign prod = {8'd0, raw} * {{PWM_BITS{1'b0}}, scale};
      assign duty = PWM_BITS'(prod >> 8);
      assign led_d[gi] = (mode_s != MODE_OFF) && (pwm_ctr_q < duty);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      p_q         <= '0;
      dir_q       <= 1'b0;
      end_pulse_q <= 1'b0;
      pwm_ctr_q   <= '0;
      led_q       <= '0;
    end else begin
      p_q         <= p_d;
      dir_q       <= dir_d;
      end_pulse_q <= end_pulse_d;
      pwm_ctr_q   <= pwm_ctr_q + 1'b1;
      led_q       <= led_d;
    end
  end

  assign led       = led_q;
  assign end_pulse = end_pulse_q;

endmodule

// File: doc/led_scanner.md
LED_SCANNER -- requirements
Module: led_scanner

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of LED outputs (>=2).
REQ-002 SHALL have parameter PWM_BITS, default 10, PWM counter and duty width.
REQ-003 SHALL have parameter FRAC_BITS, default 21, sub-channel position resolution (>= PWM_BITS); IDX_W = clog2(CHANNELS).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  synchronous active-low reset.
REQ-006 SHALL have port mode  input  2  0=off, 1=bounce, 2=wrap, 3=hold.
REQ-007 SHALL have port step  input  8  position increment per clk, unsigned.
REQ-008 SHALL have port scale  input  8  global brightness multiplier; 255 is near-full.
REQ-009 SHALL have port led  output  CHANNELS  PWM LED drive, bit i = channel i.
REQ-010 SHALL have port end_pulse  output  1  one-cycle strobe at each bounce reversal or wrap.

Function
REQ-011 SHALL hold a position register p = {idx[IDX_W-1:0], frac[FRAC_BITS-1:0]}, PMAX = CHANNELS*2^FRAC_BITS - 1, plus a direction bit dir (0=up).
REQ-012 SHALL, in bounce mode with dir=0: p+step > PMAX -> p=PMAX, dir=1, end_pulse=1; else p=p+step.
REQ-013 SHALL, in bounce mode with dir=1: p < step -> p=0, dir=0, end_pulse=1; else p=p-step.
REQ-014 SHALL, in wrap mode, ignore dir and set p=(p+step) mod (PMAX+1), pulsing end_pulse in the cycle the sum exceeds PMAX.
REQ-015 SHALL freeze p and dir in hold and off modes, with end_pulse=0.
REQ-016 SHALL treat step=0 as a frozen position with no end_pulse in every mode.
REQ-017 SHALL evaluate arithmetic at IDX_W+FRAC_BITS+1 bits so the comparisons never overflow.
REQ-018 SHALL run a free-running PWM_BITS counter pwm_ctr that increments every cycle and wraps 2^PWM_BITS-1 -> 0 in every mode.
REQ-019 SHALL compute raw brightness per channel i with F = frac[FRAC_BITS-1 -: PWM_BITS] and BMAX = 2^PWM_BITS-1: idx==i -> BMAX; idx==i-1 -> F; idx==i+1 -> BMAX-F; else 0.
REQ-020 SHALL, in wrap mode only, evaluate the neighbour terms i-1 and i+1 modulo CHANNELS; bounce and hold do not wrap neighbours.
REQ-021 SHALL compute duty_i = (raw_i * scale) >> 8, truncated to PWM_BITS.
REQ-022 SHALL register led[i] = (pwm_ctr < duty_i), using pwm_ctr, p and scale from the same cycle: one-cycle latency.
REQ-023 SHALL force led to all zeros in the cycle after mode==0 is sampled.
REQ-024 SHALL let duty=BMAX give duty (2^PWM_BITS-1)/2^PWM_BITS, which is never fully on.
REQ-025 SHALL apply a change of mode, step or scale on the next clock edge, with no pipeline flush.
REQ-026 SHALL, on a change from wrap to bounce, keep p and dir as held.

Reset
REQ-027 SHALL, when resetn=0 at a clock edge, set p=0, dir=0, pwm_ctr=0, led=0 and end_pulse=0.
REQ-028 SHALL give reset priority over every mode and input, including mid-sweep and mid-end_pulse.
REQ-029 SHALL restart from channel 0 on the first edge with resetn=1, moving upward.

Verification (CHANNELS=4, PWM_BITS=4, FRAC_BITS=4, PMAX=63)
REQ-030 SHALL cover reset then bounce, step=1, scale=255 -> p=63 after 63 cycles; dir=1 and end_pulse high exactly at the cycle p would reach 64; p back to 0 after 63 more cycles; second end_pulse.
REQ-031 SHALL cover bounce, step=200 from p=0 -> p clamps to 63, end_pulse=1, dir=1 next cycle.
REQ-032 SHALL cover wrap, step=4, p=60 -> next p=0 with end_pulse=1; with idx=3, frac=8, channel 0 raw=F=8 and channel 2 raw=7.
REQ-033 SHALL cover p=16 (idx=1, frac=0), scale=255 -> ch1 duty=14, high 14 of 16 PWM cycles; ch0 duty=14; ch2 and ch3 constantly 0.
REQ-034 SHALL cover scale=128, idx==i -> duty=7, led[i] high 7 of 16 cycles; scale=0 -> all led low.
REQ-035 SHALL cover mode=0 mid-sweep at p=37 -> led=0 next cycle and p held at 37; mode=3 -> PWM continues, p held; resetn=0 mid end_pulse -> all state zero next edge.
